// File: rtl/start_sequencer.sv
// Start/reset controller: synchronises and debounces the start switch, holds all
// core resets for a programmable time, then releases them in staggered order.
// Optional single-step clock gating is built when START_SEQ_STEP_EN is defined.
module start_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES     = 4,
    parameter int NUM_RST         = 3,
    parameter int STAGGER_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startSwitch,
`ifdef START_SEQ_STEP_EN
    input  logic               stepMode,
    input  logic               stepButton,
`endif
    output logic [NUM_RST-1:0] coreReset,
    output logic               running,
    output logic [1:0]         state,
    output logic               clkEnable
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int SW = $clog2(STAGGER_CYCLES) + 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
    localparam logic [SW-1:0] STAG_ONE  = SW'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sw_s;
    logic [DW-1:0]          deb_cnt_r;
    logic                   db_r;
    logic                   run_en_s;

    state_t                 state_r;
    logic [NUM_RST-1:0]     core_reset_r;
    logic                   running_r;
    logic                   clk_enable_r;
    logic [HW-1:0]          hold_cnt_r;
    logic [SW-1:0]          stag_cnt_r;

    assign sw_s = sync_r[SYNC_STAGES-1];

    // Metastability chain on the raw start switch
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], startSwitch};
        end
    end

    // Accept a new switch level only after it persists DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_r <= '0;
            db_r      <= 1'b0;
        end else if (sw_s != db_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                db_r      <= sw_s;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
        end else begin
            deb_cnt_r <= '0;
        end
    end

`ifdef START_SEQ_STEP_EN
    logic [SYNC_STAGES-1:0] mode_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic [DW-1:0]          btn_cnt_r;
    logic                   btn_db_r;
    logic                   btn_db_d_r;

    // Synchronise step inputs and debounce the step button
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_sync_r <= '0;
            btn_sync_r  <= '0;
            btn_cnt_r   <= '0;
            btn_db_r    <= 1'b0;
            btn_db_d_r  <= 1'b0;
        end else begin
            mode_sync_r <= {mode_sync_r[SYNC_STAGES-2:0], stepMode};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], stepButton};
            btn_db_d_r  <= btn_db_r;
            if (btn_sync_r[SYNC_STAGES-1] != btn_db_r) begin
                if (btn_cnt_r == DEB_LAST) begin
                    btn_db_r  <= btn_sync_r[SYNC_STAGES-1];
                    btn_cnt_r <= '0;
                end else begin
                    btn_cnt_r <= btn_cnt_r + DEB_ONE;
                end
            end else begin
                btn_cnt_r <= '0;
            end
        end
    end

    // In step mode only a fresh debounced press enables one core clock
    always_comb begin
        run_en_s = 1'b1;
        if (mode_sync_r[SYNC_STAGES-1]) begin
            run_en_s = btn_db_r & ~btn_db_d_r;
        end else begin
            run_en_s = 1'b1;
        end
    end
`else
    // Free-running core clock whenever the core runs
    always_comb begin
        run_en_s = 1'b1;
    end
`endif

    // Sequencer: hold, staggered release, run, abort when the switch drops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_ASSERT;
            core_reset_r <= {NUM_RST{1'b1}};
            running_r    <= 1'b0;
            clk_enable_r <= 1'b0;
            hold_cnt_r   <= '0;
            stag_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    core_reset_r <= {NUM_RST{1'b1}};
                    running_r    <= 1'b0;
                    clk_enable_r <= 1'b0;
                    hold_cnt_r   <= '0;
                    stag_cnt_r   <= '0;
                    if (db_r) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_ASSERT;
                    end
                end
                ST_HOLD: begin
                    if (!db_r) begin
                        state_r      <= ST_ASSERT;
                        core_reset_r <= {NUM_RST{1'b1}};
                        running_r    <= 1'b0;
                        clk_enable_r <= 1'b0;
                        hold_cnt_r   <= '0;
                        stag_cnt_r   <= '0;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_RELEASE;
                        core_reset_r <= core_reset_r << 1'b1;
                        hold_cnt_r   <= '0;
                        stag_cnt_r   <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_RELEASE: begin
                    // Zero-filling left shift releases channels lowest first
                    if (!db_r) begin
                        state_r      <= ST_ASSERT;
                        core_reset_r <= {NUM_RST{1'b1}};
                        running_r    <= 1'b0;
                        clk_enable_r <= 1'b0;
                        hold_cnt_r   <= '0;
                        stag_cnt_r   <= '0;
                    end else if (!core_reset_r[NUM_RST-1]) begin
                        state_r      <= ST_RUN;
                        running_r    <= 1'b1;
                        clk_enable_r <= run_en_s;
                        stag_cnt_r   <= '0;
                    end else if (stag_cnt_r == STAG_LAST) begin
                        core_reset_r <= core_reset_r << 1'b1;
                        stag_cnt_r   <= '0;
                    end else begin
                        stag_cnt_r <= stag_cnt_r + STAG_ONE;
                    end
                end
                ST_RUN: begin
                    if (!db_r) begin
                        state_r      <= ST_ASSERT;
                        core_reset_r <= {NUM_RST{1'b1}};
                        running_r    <= 1'b0;
                        clk_enable_r <= 1'b0;
                        hold_cnt_r   <= '0;
                        stag_cnt_r   <= '0;
                    end else begin
                        core_reset_r <= '0;
                        running_r    <= 1'b1;
                        clk_enable_r <= run_en_s;
                    end
                end
                default: begin
                    state_r      <= ST_ASSERT;
                    core_reset_r <= {NUM_RST{1'b1}};
                    running_r    <= 1'b0;
                    clk_enable_r <= 1'b0;
                    hold_cnt_r   <= '0;
                    stag_cnt_r   <= '0;
                end
            endcase
        end
    end

    assign coreReset = core_reset_r;
    assign running   = running_r;
    assign state     = state_r;
    assign clkEnable = clk_enable_r;

endmodule

// File: tb/tb_start_sequencer.sv
// Self-checking bench for start_sequencer: timing-rule model checked every cycle
// plus directed literal checks of the key edges.
module tb_start_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 4;
    localparam int NR   = 3;
    localparam int STAG = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          startSwitch;
    logic [NR-1:0] coreReset;
    logic          running;
    logic [1:0]    state;
    logic          clkEnable;
`ifdef START_SEQ_STEP_EN
    logic          stepMode;
    logic          stepButton;
`endif

    int checks = 0;
    int errors = 0;

    start_sequencer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .NUM_RST(NR), .STAGGER_CYCLES(STAG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startSwitch(startSwitch),
`ifdef START_SEQ_STEP_EN
        .stepMode(stepMode),
        .stepButton(stepButton),
`endif
        .coreReset(coreReset),
        .running(running),
        .state(state),
        .clkEnable(clkEnable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: delayed switch samples, debounced level, and k = number of edges
    // the sequencer has seen the debounced level high (0 means asserting).
    logic [SYNC-1:0] m_sync;
    bit              m_db;
    bit              m_s_seen;
    bit              m_db_prev;
    int              m_streak;
    int              m_k;
    int              m_j;
    int              m_rel;
    logic [1:0]      e_state;
    logic [NR-1:0]   e_core;
    logic            e_run;
    logic [NR-1:0]   ones;

    always @(posedge clk) begin
        ones = '1;
        if (reset) begin
            m_sync = '0; m_db = 1'b0; m_streak = 0; m_k = 0;
        end else begin
            m_db_prev = m_db;
            m_s_seen  = m_sync[SYNC-1];
            m_sync    = {m_sync[SYNC-2:0], startSwitch};
            if (m_s_seen != m_db) m_streak++; else m_streak = 0;
            if (m_streak == DEB) begin
                m_db = ~m_db; m_streak = 0;
            end
            if (m_db_prev) m_k++; else m_k = 0;
        end
        e_run = 1'b0;
        if (m_k == 0) begin
            e_state = 2'd0; m_rel = 0;
        end else if (m_k <= HOLD) begin
            e_state = 2'd1; m_rel = 0;
        end else begin
            m_j   = m_k - HOLD - 1;
            m_rel = 1 + m_j / STAG;
            if (m_rel > NR) m_rel = NR;
            if (m_j >= (NR - 1) * STAG + 1) begin
                e_state = 2'd3; e_run = 1'b1;
            end else begin
                e_state = 2'd2;
            end
        end
        e_core = ones << m_rel;
        #1;
        chk("mdl_state", 32'(state), 32'(e_state));
        chk("mdl_core", 32'(coreReset), 32'(e_core));
        chk("mdl_running", 32'(running), 32'(e_run));
`ifndef START_SEQ_STEP_EN
        chk("mdl_clken", 32'(clkEnable), 32'(e_run));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Full rise sequence; edge 0 is the first edge sampling the switch high
    task automatic rise_check(input string tag);
        for (int e = 0; e <= 19; e++) begin
            tick();
            case (e)
                9:  chk({tag, "_e9_state"}, 32'(state), 32'd0);
                10: chk({tag, "_e10_state"}, 32'(state), 32'd1);
                13: chk({tag, "_e13_core"}, 32'(coreReset), 32'b111);
                14: begin
                    chk({tag, "_e14_core"}, 32'(coreReset), 32'b110);
                    chk({tag, "_e14_state"}, 32'(state), 32'd2);
                end
                16: chk({tag, "_e16_core"}, 32'(coreReset), 32'b100);
                18: begin
                    chk({tag, "_e18_core"}, 32'(coreReset), 32'b000);
                    chk({tag, "_e18_run"}, 32'(running), 32'd0);
                end
                19: begin
                    chk({tag, "_e19_run"}, 32'(running), 32'd1);
                    chk({tag, "_e19_state"}, 32'(state), 32'd3);
                end
                default: ;
            endcase
        end
    endtask

`ifdef START_SEQ_STEP_EN
    bit cnt_en = 1'b0;
    int hi_cycles = 0;
    int rises = 0;
    logic clken_d = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cnt_en && clkEnable) hi_cycles++;
        if (cnt_en && clkEnable && !clken_d) rises++;
        clken_d = clkEnable;
    end
`endif

    bit left_assert;

    initial begin
        reset = 1'b1;
        startSwitch = 1'b0;
`ifdef START_SEQ_STEP_EN
        stepMode = 1'b0;
        stepButton = 1'b0;
`endif
        tick();
        chk("rst_core", 32'(coreReset), 32'b111);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        startSwitch = 1'b1;
        rise_check("rise1");

        // Switch off from RUN: all resets back at edge 10
        startSwitch = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 9) chk("off_e9_core", 32'(coreReset), 32'b000);
            if (e == 10) begin
                chk("off_e10_core", 32'(coreReset), 32'b111);
                chk("off_e10_run", 32'(running), 32'd0);
                chk("off_e10_state", 32'(state), 32'd0);
            end
        end

        startSwitch = 1'b1;
        rise_check("rise2");
        startSwitch = 1'b0;
        repeat (12) tick();

        // Five-cycle glitch must be rejected
        startSwitch = 1'b1;
        repeat (5) tick();
        startSwitch = 1'b0;
        left_assert = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (state != 2'd0 || coreReset != 3'b111) left_assert = 1'b1;
        end
        chk("pulse_stayed_assert", 32'(left_assert), 32'd0);

        // Abort mid-release: switch low from edge 8, db falls after edge 17
        startSwitch = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            if (e == 8) startSwitch = 1'b0;
            tick();
            if (e == 14) chk("abort_e14_core", 32'(coreReset), 32'b110);
            if (e == 17) begin
                chk("abort_e17_core", 32'(coreReset), 32'b100);
                chk("abort_e17_state", 32'(state), 32'd2);
            end
            if (e == 18) begin
                chk("abort_e18_core", 32'(coreReset), 32'b111);
                chk("abort_e18_state", 32'(state), 32'd0);
            end
            if (e == 21) chk("abort_e21_core", 32'(coreReset), 32'b111);
        end

        // Reset pulse while running with the switch held on
        startSwitch = 1'b1;
        repeat (20) tick();
        chk("pre_rst_running", 32'(running), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_core", 32'(coreReset), 32'b111);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_running", 32'(running), 32'd0);
        reset = 1'b0;
        rise_check("rise3");

`ifdef START_SEQ_STEP_EN
        tick();
        chk("step_free_clken", 32'(clkEnable), 32'd1);
        stepMode = 1'b1;
        repeat (5) tick();
        chk("step_idle_clken", 32'(clkEnable), 32'd0);
        cnt_en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            stepButton = 1'b1;
            repeat (14) tick();
            stepButton = 1'b0;
            repeat (14) tick();
        end
        cnt_en = 1'b0;
        chk("step_pulse_count", 32'(rises), 32'd3);
        chk("step_high_cycles", 32'(hi_cycles), 32'd3);
        stepMode = 1'b0;
        repeat (4) tick();
        chk("step_off_clken", 32'(clkEnable), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
